// File: rtl/key_load_pkg.sv
// Shared types and constants for the key load sequencer.
package key_load_pkg;

  localparam int unsigned KEY_WIDTH = 29;
  localparam int unsigned CNT_W     = $clog2(KEY_WIDTH + 1);

  localparam logic [KEY_WIDTH-1:0] DECOY_KEY_DEFAULT = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PARITY,
    COMMIT,
    ARMED,
    ERROR
  } state_t;

endpackage

// File: rtl/key_load_sequencer_if.sv
// Serial key-bit handshake between the on-chip key store and the sequencer.
interface key_load_sequencer_if;

  logic key_bit_in;
  logic key_bit_valid;
  logic key_bit_ready;

  modport master (output key_bit_in, output key_bit_valid, input  key_bit_ready);
  modport slave  (input  key_bit_in, input  key_bit_valid, output key_bit_ready);

endinterface

// File: rtl/key_load_timeout.sv
// Saturating idle-cycle counter; expired_c flags TIMEOUT-1 stalled cycles.
module key_load_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + TW'(1);
    end
  end

  assign expired_c = (count == LAST);

endmodule

// File: rtl/key_load_sequencer.sv
// Serial unlock-key loader for the locked c432 core; holds DECOY_KEY until a full key commits.
// Optional trailing even-parity bit check enabled by defining KEY_LOAD_PARITY_EN.
module key_load_sequencer
  import key_load_pkg::*;
#(
  parameter int unsigned           TIMEOUT   = 64,
  parameter logic [KEY_WIDTH-1:0]  DECOY_KEY = DECOY_KEY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  key_load_sequencer_if.slave  bus,
  output logic [KEY_WIDTH-1:0] keyinput,
  output logic                 key_ok,
  output logic                 busy,
  output logic                 load_err
);

  state_t               state, state_next;
  logic [KEY_WIDTH-1:0] shadow, shadow_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [KEY_WIDTH-1:0] keyinput_d;
  logic                 key_ok_d, busy_d, load_err_d, ready_d;

  logic transfer_c, in_load_c, last_bit_c, expired_c;

  assign transfer_c = bus.key_bit_valid & bus.key_bit_ready;
  assign in_load_c  = (state == LOAD) || (state == PARITY);
  assign last_bit_c = (cnt == CNT_W'(KEY_WIDTH - 1));

  key_load_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start | transfer_c | ~in_load_c),
    .enable    (in_load_c & ~transfer_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Restart wins over every other event in every state.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (transfer_c) begin
            if (last_bit_c) begin
`ifdef KEY_LOAD_PARITY_EN
              state_next = PARITY;
`else
              state_next = COMMIT;
`endif
            end
          end else if (expired_c) begin
            state_next = ERROR;
          end
        end
`ifdef KEY_LOAD_PARITY_EN
        PARITY: begin
          if (transfer_c) begin
            state_next = (^{shadow, bus.key_bit_in}) ? ERROR : COMMIT;
          end else if (expired_c) begin
            state_next = ERROR;
          end
        end
`endif
        COMMIT:  state_next = ARMED;
        default: state_next = state;
      endcase
    end
  end

  // Next values of the registered outputs and the assembly shadow.
  always_comb begin
    keyinput_d = keyinput;
    key_ok_d   = key_ok;
    busy_d     = busy;
    load_err_d = load_err;
    shadow_d   = shadow;
    cnt_d      = cnt;
    ready_d    = (state_next == LOAD) || (state_next == PARITY);
    if (start) begin
      cnt_d      = '0;
      load_err_d = 1'b0;
      key_ok_d   = 1'b0;
      keyinput_d = DECOY_KEY;
      busy_d     = 1'b1;
    end else begin
      if ((state == LOAD) && transfer_c) begin
        shadow_d[cnt] = bus.key_bit_in;
        cnt_d         = cnt + CNT_W'(1);
      end
      if ((state_next == ERROR) && (state != ERROR)) begin
        keyinput_d = DECOY_KEY;
        key_ok_d   = 1'b0;
        busy_d     = 1'b0;
        load_err_d = 1'b1;
      end
      if (state == COMMIT) begin
        keyinput_d = shadow;
        key_ok_d   = 1'b1;
        busy_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyinput          <= DECOY_KEY;
      key_ok            <= 1'b0;
      busy              <= 1'b0;
      load_err          <= 1'b0;
      bus.key_bit_ready <= 1'b0;
      shadow            <= '0;
      cnt               <= '0;
    end else begin
      keyinput          <= keyinput_d;
      key_ok            <= key_ok_d;
      busy              <= busy_d;
      load_err          <= load_err_d;
      bus.key_bit_ready <= ready_d;
      shadow            <= shadow_d;
      cnt               <= cnt_d;
    end
  end

endmodule

// File: tb/tb_key_load_sequencer.sv
// Scoreboard bench for key_load_sequencer: directed key loads, timeout, restart and parity cases.
module tb_key_load_sequencer;
  import key_load_pkg::*;

  typedef struct packed {
    logic                 err;
    logic [KEY_WIDTH-1:0] key;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [KEY_WIDTH-1:0] keyinput;
  logic                 key_ok, busy, load_err;

  key_load_sequencer_if bus ();

  key_load_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .keyinput (keyinput),
    .key_ok   (key_ok),
    .busy     (busy),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    bus.key_bit_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives n bits LSB-first; returns 1 time unit after the edge of the last transfer.
  task automatic send_bits(input logic [31:0] bits, input int n, input bit toggle);
    int waits;
    for (int i = 0; i < n; i++) begin
      waits = 0;
      bus.key_bit_in    = bits[i];
      bus.key_bit_valid = 1'b1;
      @(negedge clk);
      while (!bus.key_bit_ready && waits < 8) begin
        @(negedge clk);
        waits++;
      end
      if (waits != 0) stalls++;
      @(posedge clk); #1;
      if (toggle && i != n - 1) begin
        bus.key_bit_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.key_bit_valid = 1'b0;
  endtask

  task automatic send_key(input logic [KEY_WIDTH-1:0] key, input bit toggle);
    send_bits(32'(key), KEY_WIDTH, toggle);
`ifdef KEY_LOAD_PARITY_EN
    send_bits(32'(^key), 1, toggle);
`endif
  endtask

  // Full load with commit timing checked relative to the final accepted bit.
  task automatic load_and_commit(input string tag, input logic [KEY_WIDTH-1:0] key, input bit toggle);
    exp_q.push_back('{err: 1'b0, key: key});
    pulse_start();
    check({tag, "_busy_after_start"}, 32'(busy), 1);
    send_key(key, toggle);
    check({tag, "_no_ok_at_last_bit"}, 32'(key_ok), 0);
    check({tag, "_decoy_at_last_bit"}, 32'(keyinput), 0);
    @(posedge clk); #1;
    check({tag, "_key_ok"}, 32'(key_ok), 1);
    check({tag, "_keyinput"}, 32'(keyinput), 32'(key));
    check({tag, "_busy_done"}, 32'(busy), 0);
    check({tag, "_ready_low"}, 32'(bus.key_bit_ready), 0);
  endtask

  // Monitor: every rising key_ok / load_err must match the next queued expectation.
  initial begin : monitor
    logic prev_ok, prev_err;
    exp_t e;
    prev_ok  = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ((key_ok && !prev_ok) || (load_err && !prev_err))) begin
        check("mon_event_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("mon_event_kind", 32'(load_err), 32'(e.err));
          check("mon_keyinput", 32'(keyinput), 32'(e.key));
          check("mon_key_ok", 32'(key_ok), 32'(!e.err));
        end
      end
      prev_ok  = key_ok;
      prev_err = load_err;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    bus.key_bit_in    = 1'b0;
    bus.key_bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_keyinput", 32'(keyinput), 0);
    check("rst_key_ok", 32'(key_ok), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_load_err", 32'(load_err), 0);
    check("rst_ready", 32'(bus.key_bit_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    stalls = 0;
    load_and_commit("cont", 29'h0A5C3F1, 1'b0);
    check("cont_ready_every_cycle", 32'(stalls), 0);

    stalls = 0;
    load_and_commit("toggle", 29'h0A5C3F1, 1'b1);
    check("toggle_ready_held", 32'(stalls), 0);

    // Ten bits then silence: ERROR after exactly TIMEOUT idle edges.
    exp_q.push_back('{err: 1'b1, key: 29'h0});
    pulse_start();
    send_bits(32'h0000_03A5, 10, 1'b0);
    n = 0;
    while (!load_err && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_edges", 32'(n), 64);
    check("timeout_keyinput", 32'(keyinput), 0);
    check("timeout_ready", 32'(bus.key_bit_ready), 0);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_key_ok", 32'(key_ok), 0);

    load_and_commit("recover", 29'h1FFFFFFF, 1'b0);
    check("recover_err_cleared", 32'(load_err), 0);

    pulse_start();
    check("rearm_decoy", 32'(keyinput), 0);
    check("rearm_key_ok", 32'(key_ok), 0);
    load_and_commit("reload", 29'h0000001, 1'b0);

    // start coincides with the final bit: restart, no commit.
    pulse_start();
    send_bits(32'h1555_5555, KEY_WIDTH - 1, 1'b0);
    bus.key_bit_in    = 1'b1;
    bus.key_bit_valid = 1'b1;
    start             = 1'b1;
    @(posedge clk); #1;
    start             = 1'b0;
    bus.key_bit_valid = 1'b0;
    check("race_key_ok", 32'(key_ok), 0);
    check("race_keyinput", 32'(keyinput), 0);
    check("race_busy", 32'(busy), 1);
    check("race_ready", 32'(bus.key_bit_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    check("race_still_no_commit", 32'(key_ok), 0);
    exp_q.push_back('{err: 1'b0, key: 29'h0000005});
    send_key(29'h0000005, 1'b0);
    @(posedge clk); #1;
    check("race_reload_keyinput", 32'(keyinput), 32'h0000005);

`ifdef KEY_LOAD_PARITY_EN
    exp_q.push_back('{err: 1'b1, key: 29'h0});
    pulse_start();
    send_bits(32'h0000003, KEY_WIDTH, 1'b0);
    send_bits(32'h1, 1, 1'b0);
    check("parity_bad_err", 32'(load_err), 1);
    check("parity_bad_keyinput", 32'(keyinput), 0);
    exp_q.push_back('{err: 1'b0, key: 29'h0000003});
    pulse_start();
    send_bits(32'h0000003, KEY_WIDTH, 1'b0);
    send_bits(32'h0, 1, 1'b0);
    @(posedge clk); #1;
    check("parity_good_ok", 32'(key_ok), 1);
    check("parity_good_keyinput", 32'(keyinput), 32'h0000003);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
